fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage. It is the producer side of the IF/ID pipeline register.
//  Owns the PC and issues single-outstanding requests to instruction memory.
//  Buffers one returned instruction, then presents ins/pc/pc+4 plus the IF/ID
//  en/clr controls. Handles hazard-unit stalls and branch/jump redirects from EX.
// PARAMETERS
//  DATA_WIDTH  32            instruction width
//  PC_WIDTH    32            PC / address width
//  RESET_PC    32'h0000_0000 first fetch address after reset
//  NOP_INSN    32'h0000_0013 bubble value (addi x0,x0,0) driven on ins_out when empty
// PORTS
//  clk            in   1           clock, all state on posedge
//  rst            in   1           synchronous reset, active-low (0 = reset)
//  stall_i        in   1           hazard unit: hold IF/ID contents
//  redirect_i     in   1           branch/jump taken: flush and refetch
//  redirect_pc_i  in   PC_WIDTH    redirect target
//  imem_req_o     out  1           fetch request valid
//  imem_addr_o    out  PC_WIDTH    fetch address (= PC register)
//  imem_ready_i   in   1           memory accepts request this cycle
//  imem_rvalid_i  in   1           response valid (>=1 cycle after accept)
//  imem_rdata_i   in   DATA_WIDTH  response instruction
//  ins_out        out  DATA_WIDTH  buffered instruction to IF/ID
//  pc_out         out  PC_WIDTH    address of ins_out
//  pc_plus4_out   out  PC_WIDTH    pc_out + 4
//  valid_out      out  1           buffer holds a real instruction
//  ifid_en        out  1           IF/ID load enable
//  ifid_clr       out  1           IF/ID flush
// BEHAVIOUR
//  Reset (rst=0 at posedge): pc<=RESET_PC, state<=REQ, valid_out<=0, ins_out<=NOP_INSN,
//   pc_out<=0, pc_plus4_out<=0. imem_req_o=0 while rst=0. imem shares this reset;
//   responses to pre-reset requests are never delivered.
//  States: REQ (may issue), WAIT (one request outstanding), DROP (outstanding, discard).
//  imem_req_o = (state==REQ) & buf_free & ~redirect_i & rst;
//   buf_free = ~valid_out | ifid_en.
//  REQ: on imem_req_o & imem_ready_i -> WAIT. The address is held stable until accepted.
//  WAIT: on imem_rvalid_i -> capture rdata into ins_out, pc into pc_out, pc+4 into
//   pc_plus4_out; set valid_out=1; pc<=pc+4; -> REQ.
//  DROP: on imem_rvalid_i -> discard data, no pc change; -> REQ.
//  ifid_en  = (valid_out & ~stall_i) | redirect_i. valid_out clears on consumption
//   unless it is refilled in the same cycle.
//  ifid_clr = redirect_i (combinational, 1-cycle pulse per redirect cycle).
//  Stall: while stall_i=1 and valid_out=1, all outputs hold, no new request is issued,
//   and any outstanding response is still captured only if the buffer is free.
//   Otherwise the FSM remains in WAIT with rvalid ignored. Memory must hold rvalid
//   until captured.
//  Redirect (priority over stall and rvalid): pc<={redirect_pc_i[PC_WIDTH-1:2],2'b00};
//   valid_out<=0; ins_out<=NOP_INSN. REQ stays REQ; WAIT w/o rvalid -> DROP;
//   WAIT/DROP with rvalid same cycle -> REQ, data dropped; DROP stays DROP.
//  Throughput: 1 instruction per 2 cycles with zero-wait memory (REQ, WAIT).
//  PC arithmetic modulo 2^PC_WIDTH; 0xFFFF_FFFC + 4 wraps to 0, no flag.
//  Latency: redirect at cycle t -> first request to new target at t+1 (if no drop needed).
// TESTING
//  1 Reset: rst=0 2 cycles -> imem_req_o=0, valid_out=0, ins_out=0x00000013;
//    1st cycle after release: imem_req_o=1, imem_addr_o=0x0.
//  2 Zero-wait stream: ready=1, rvalid 1 cycle after accept, data=addr^0xA5A5_0000
//    -> pc_out 0,4,8 with valid_out; pc_plus4_out=pc_out+4; 1 insn per 2 cycles.
//  3 Stall: valid_out=1, stall_i=1 for 3 cycles -> ifid_en=0, outputs stable,
//    imem_req_o=0. Release -> ifid_en=1, fetch resumes at next pc.
//  4 Redirect in WAIT: redirect_pc=0x100, rvalid 2 cycles later with 0xDEADBEEF
//    -> ifid_clr=1 for 1 cycle, 0xDEADBEEF never on ins_out, next imem_addr_o=0x100.
//  5 Misaligned + simultaneous: redirect_pc=0x103 in same cycle as rvalid
//    -> data dropped, next imem_addr_o=0x100, valid_out=0.
//  6 Reset mid-WAIT and wrap: rst=0 while in WAIT -> next req at RESET_PC;
//    RESET_PC=0xFFFF_FFFC -> second request at 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage feeding the IF/ID register
// Owns the PC, keeps one imem request outstanding, buffers one instruction.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSN   = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  output logic                  imem_req_o,
  output logic [PC_WIDTH-1:0]   imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] ins_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   pc_plus4_out,
  output logic                  valid_out,
  output logic                  ifid_en,
  output logic                  ifid_clr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   pc_out_q, pc_out_d;
  logic [PC_WIDTH-1:0]   pc4_q, pc4_d;
  logic [DATA_WIDTH-1:0] ins_q, ins_d;
  logic                  valid_q, valid_d;
  logic                  buf_free;
  logic [PC_WIDTH-1:0]   pc_inc;

  assign ifid_en      = (valid_q & ~stall_i) | redirect_i;
  assign ifid_clr     = redirect_i;
  assign buf_free     = ~valid_q | ifid_en;
  assign imem_req_o   = (state_q == S_REQ) & buf_free & ~redirect_i & rst;
  assign imem_addr_o  = pc_q;
  assign pc_inc       = pc_q + PC_WIDTH'(4);
  assign ins_out      = ins_q;
  assign pc_out       = pc_out_q;
  assign pc_plus4_out = pc4_q;
  assign valid_out    = valid_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    pc4_d    = pc4_q;
    ins_d    = ins_q;
    valid_d  = valid_q;
    if (redirect_i) begin
      pc_d    = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
      valid_d = 1'b0;
      ins_d   = NOP_INSN;
      // An in-flight response that has not arrived yet must be swallowed later.
      state_d = (state_q != S_REQ && !imem_rvalid_i) ? S_DROP : S_REQ;
    end else begin
      if (ifid_en) begin
        valid_d = 1'b0;
        ins_d   = NOP_INSN;
      end
      case (state_q)
        S_REQ: begin
          if (imem_req_o && imem_ready_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i && buf_free) begin
            state_d  = S_REQ;
            ins_d    = imem_rdata_i;
            pc_out_d = pc_q;
            pc4_d    = pc_inc;
            valid_d  = 1'b1;
            pc_d     = pc_inc;
          end
        end
        S_DROP: begin
          if (imem_rvalid_i) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      pc4_q    <= '0;
      ins_q    <= NOP_INSN;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      pc4_q    <= pc4_d;
      ins_q    <= ins_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst, stall_i, redirect_i, imem_ready_i, imem_rvalid_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, valid_out, ifid_en, ifid_clr;
  logic [31:0] imem_addr_o, ins_out, pc_out, pc_plus4_out;

  logic        rst2, rdy2, rv2;
  logic [31:0] rd2;
  logic        req2, v2, en2, clr2;
  logic [31:0] addr2, ins2, pc2, pc42;

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .ins_out(ins_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .valid_out(valid_out), .ifid_en(ifid_en), .ifid_clr(ifid_clr)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst2), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ready_i(rdy2), .imem_rvalid_i(rv2), .imem_rdata_i(rd2),
    .ins_out(ins2), .pc_out(pc2), .pc_plus4_out(pc42),
    .valid_out(v2), .ifid_en(en2), .ifid_clr(clr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, passed = 0, fails = 0;

  // Reference model: next fetch address, the one-entry buffer, and whether a
  // request is in flight (and whether its data is to be thrown away).
  logic [31:0] m_pc = 32'h0, m_ins = NOP, m_bpc = 32'h0, m_bpc4 = 32'h0;
  bit          m_v = 0, m_out = 0, m_disc = 0;

  // Memory: fixed or random latency, holds rvalid until the data is taken.
  bit          mem_busy = 0;
  int          mem_cnt = 0, mem_lat = 1;
  logic [31:0] mem_data = 32'h0;
  bit          ovr_en = 0;
  logic [31:0] ovr_data = 32'h0;
  bit          seen_bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit en, free, req, taken;
    imem_rvalid_i = mem_busy && (mem_cnt == 0);
    imem_rdata_i  = imem_rvalid_i ? mem_data : $urandom;
    @(negedge clk);
    en   = (m_v && !stall_i) || redirect_i;
    free = !m_v || en;
    req  = !m_out && free && !redirect_i && rst;
    chk("req", imem_req_o, req);
    if (req) chk("addr", imem_addr_o, m_pc);
    chk("valid", valid_out, m_v);
    chk("ifid_en", ifid_en, en);
    chk("ifid_clr", ifid_clr, redirect_i);
    chk("ins", ins_out, m_ins);
    chk("pc_out", pc_out, m_bpc);
    chk("pc_plus4", pc_plus4_out, m_bpc4);
    if (ins_out === 32'hDEAD_BEEF) seen_bad = 1;
    @(posedge clk);
    if (!rst) begin
      m_pc = 32'h0; m_ins = NOP; m_bpc = 32'h0; m_bpc4 = 32'h0;
      m_v = 0; m_out = 0; m_disc = 0; mem_busy = 0;
    end else begin
      if (mem_busy && mem_cnt > 0) mem_cnt--;
      if (redirect_i) begin
        m_pc = {redirect_pc_i[31:2], 2'b00};
        m_v = 0; m_ins = NOP;
        if (m_out && imem_rvalid_i) begin
          m_out = 0; mem_busy = 0;
        end else if (m_out) m_disc = 1;
      end else begin
        taken = 0;
        if (en) begin m_v = 0; m_ins = NOP; end
        if (!m_out) begin
          if (req && imem_ready_i) begin
            m_out = 1; m_disc = 0; mem_busy = 1;
            mem_cnt  = (mem_lat == 0) ? int'($urandom_range(2, 0)) : mem_lat - 1;
            mem_data = ovr_en ? ovr_data : (m_pc ^ 32'hA5A5_0000);
          end
        end else if (imem_rvalid_i) begin
          if (m_disc) taken = 1;
          else if (free) begin
            m_ins = imem_rdata_i; m_bpc = m_pc; m_bpc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4; m_v = 1; taken = 1;
          end
          if (taken) begin m_out = 0; mem_busy = 0; end
        end
      end
    end
    #1;
  endtask

  initial begin
    rst = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0; imem_ready_i = 1;
    imem_rvalid_i = 0; imem_rdata_i = 0;
    rst2 = 0; rdy2 = 1; rv2 = 0; rd2 = 0;
    @(posedge clk); #1;

    // Reset held, then first request at RESET_PC.
    repeat (2) cycle();
    rst = 1;
    cycle();

    // Zero-wait stream.
    repeat (8) cycle();

    // Stall with a full buffer.
    for (int i = 0; i < 6 && !m_v; i++) cycle();
    stall_i = 1;
    repeat (3) cycle();
    stall_i = 0;
    repeat (4) cycle();

    // Redirect while a slow response is in flight.
    mem_lat = 3; ovr_en = 1; ovr_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 8 && !m_out; i++) cycle();
    ovr_en = 0;
    seen_bad = 0;
    redirect_i = 1; redirect_pc_i = 32'h100;
    cycle();
    redirect_i = 0;
    repeat (6) cycle();
    chk("no_deadbeef", seen_bad, 0);

    // Misaligned redirect in the same cycle as rvalid.
    mem_lat = 1;
    for (int i = 0; i < 8 && !(mem_busy && mem_cnt == 0); i++) cycle();
    redirect_i = 1; redirect_pc_i = 32'h103;
    cycle();
    redirect_i = 0;
    repeat (3) cycle();

    // Reset while waiting on memory.
    mem_lat = 3;
    for (int i = 0; i < 8 && !m_out; i++) cycle();
    rst = 0;
    cycle();
    rst = 1;
    repeat (3) cycle();

    // Random traffic.
    mem_lat = 0;
    repeat (400) begin
      stall_i       = ($urandom_range(3, 0) == 0);
      redirect_i    = ($urandom_range(9, 0) == 0);
      redirect_pc_i = $urandom;
      imem_ready_i  = ($urandom_range(9, 0) < 7);
      rst           = ($urandom_range(49, 0) != 0);
      cycle();
    end
    stall_i = 0; redirect_i = 0; rst = 1; imem_ready_i = 1;

    // PC wrap from RESET_PC = 0xFFFF_FFFC.
    @(negedge clk);
    chk("wrap_rst_req", req2, 0);
    @(posedge clk); #1 rst2 = 1;
    @(negedge clk);
    chk("wrap_req", req2, 1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    @(posedge clk); #1 rv2 = 1; rd2 = 32'h1234_5678;
    @(negedge clk);
    chk("wrap_wait_req", req2, 0);
    @(posedge clk); #1 rv2 = 0;
    @(negedge clk);
    chk("wrap_valid", v2, 1);
    chk("wrap_ins", ins2, 32'h1234_5678);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc42, 32'h0);
    chk("wrap_req2", req2, 1);
    chk("wrap_addr1", addr2, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
